// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_bitstream_loader
// Brief    : Serialises host configuration words onto a ccff chain head with a
//            gated shift enable, accumulating parity of the bits read back.
// Revision : 1.0
// ============================================================================
module ccff_bitstream_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 18,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              readback_parity
);

    localparam int BUF_CNT_W = $clog2(WORD_W + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_W-1:0]     c_CHAIN_LEN = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]     c_LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]     c_BIT_ONE   = CNT_W'(1);
    localparam logic [BUF_CNT_W-1:0] c_WORD_W    = BUF_CNT_W'(WORD_W);
    localparam logic [BUF_CNT_W-1:0] c_BUF_ONE   = BUF_CNT_W'(1);

    logic [1:0]           r_state;
    logic [WORD_W-1:0]    r_buf;
    logic [BUF_CNT_W-1:0] r_buf_cnt;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_rb_par;

    logic w_in_load;
    logic w_shift;
    logic w_word_ready;
    logic w_fetch;
    logic w_last_bit;

    // Every output is a pure decode of registered state; inputs never reach
    // an output in the same cycle.
    assign w_in_load    = (r_state == c_LOAD);
    assign w_shift      = w_in_load && (r_buf_cnt != '0);
    assign w_word_ready = w_in_load && (r_buf_cnt == '0) && (r_bit_cnt < c_CHAIN_LEN);
    assign w_fetch      = w_word_ready && word_valid;
    assign w_last_bit   = w_shift && (r_bit_cnt == c_LAST_BIT);

    assign word_ready      = w_word_ready;
    assign shift_en        = w_shift;
    assign ccff_head       = w_shift & r_buf[0];
    assign busy            = w_in_load;
    assign done            = (r_state == c_DONE);
    assign readback_parity = r_rb_par;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state   <= c_IDLE;
            r_buf     <= '0;
            r_buf_cnt <= '0;
            r_bit_cnt <= '0;
            r_rb_par  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state   <= c_LOAD;
                        r_buf_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_rb_par  <= 1'b0;
                    end
                end
                c_LOAD: begin
                    if (w_fetch) begin
                        r_buf     <= word_data;
                        r_buf_cnt <= c_WORD_W;
                    end else if (w_shift) begin
                        r_buf     <= r_buf >> 1;
                        r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                        r_rb_par  <= r_rb_par ^ ccff_tail;
                        // Leftover bits of the final word are dropped here.
                        if (w_last_bit) begin
                            r_buf_cnt <= '0;
                            r_state   <= c_DONE;
                        end else begin
                            r_buf_cnt <= r_buf_cnt - c_BUF_ONE;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// Directed bench for ccff_bitstream_loader: behavioural chains on an 18-bit
// and a 16-bit instance, checking latency, chain contents, parity and protocol.
module tb_ccff_bitstream_loader;

    logic        prog_clk = 1'b0;
    logic        pReset   = 1'b1;
    logic        start    = 1'b0;
    logic [7:0]  word_data = 8'h00;
    logic        word_valid = 1'b0;
    logic        word_ready, ccff_head, shift_en, ccff_tail, busy, done, readback_parity;

    logic        start16 = 1'b0;
    logic [7:0]  data16  = 8'h00;
    logic        valid16 = 1'b0;
    logic        ready16, head16, shift16, tail16, busy16, done16, par16;

    logic [17:0] chain;
    logic [15:0] chain16 = 16'h0007;
    logic        preload_en  = 1'b0;
    logic [17:0] preload_val = 18'h0;

    int checks = 0;
    int errors = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(18)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .ccff_head(ccff_head), .shift_en(shift_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .readback_parity(readback_parity)
    );

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut16 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start16),
        .word_data(data16), .word_valid(valid16), .word_ready(ready16),
        .ccff_head(head16), .shift_en(shift16), .ccff_tail(tail16),
        .busy(busy16), .done(done16), .readback_parity(par16)
    );

    // chain[0] is the flop nearest ccff_tail; the head end enters at the MSB.
    always @(posedge prog_clk) begin
        if (preload_en) chain <= preload_val;
        else if (shift_en) chain <= {ccff_head, chain[17:1]};
    end
    assign ccff_tail = chain[0];

    always @(posedge prog_clk) begin
        if (shift16) chain16 <= {head16, chain16[15:1]};
    end
    assign tail16 = chain16[0];

    task automatic preload(input logic [17:0] v);
        @(negedge prog_clk);
        preload_en  = 1'b1;
        preload_val = v;
        @(negedge prog_clk);
        preload_en  = 1'b0;
    endtask

    // Host driver: supplies three words, optionally stalls before one of them,
    // optionally pokes start during LOAD and during the DONE cycle.
    task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int stall_word, input int stall_len, input bit poke,
                           output int cyc_done, output int hs, output int done_hi,
                           output int busy_after, output int stall_bad);
        logic [7:0]  words [3];
        logic [17:0] chain_prev;
        int cyc, post, idx, stall_left;
        bit will_hs, stalling;
        words[0] = w0; words[1] = w1; words[2] = w2;
        idx = 0; stall_left = stall_len; cyc = 0; post = 0;
        cyc_done = -1; hs = 0; done_hi = 0; busy_after = 0; stall_bad = 0;
        @(negedge prog_clk);
        start = 1'b1; word_valid = 1'b1; word_data = w0;
        @(posedge prog_clk); #1;
        cyc = 1; start = 1'b0;
        for (int k = 0; k < 100 && post < 4; k++) begin
            @(negedge prog_clk);
            if (cyc_done >= 0) begin
                post++;
                if (busy === 1'b1) busy_after++;
            end
            if (done === 1'b1) begin
                done_hi++;
                if (cyc_done < 0) cyc_done = cyc;
            end
            start = poke && (k == 6 || done === 1'b1);
            stalling = (idx == stall_word) && (stall_left > 0) && (word_ready === 1'b1);
            if (stalling) begin
                stall_left--;
                word_valid = 1'b0;
                if (shift_en !== 1'b0 || ccff_head !== 1'b0) stall_bad++;
            end else begin
                word_valid = 1'b1;
            end
            word_data = (idx < 3) ? words[idx] : 8'hEE;
            will_hs = (word_ready === 1'b1) && word_valid;
            chain_prev = chain;
            @(posedge prog_clk); #1;
            cyc++;
            if (will_hs) begin hs++; idx++; end
            if (stalling && chain !== chain_prev) stall_bad++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge prog_clk);
        checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL reset_word_ready got %b expected 0", word_ready); end
        checks++; if (ccff_head !== 1'b0) begin errors++; $display("FAIL reset_ccff_head got %b expected 0", ccff_head); end
        checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en got %b expected 0", shift_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (readback_parity !== 1'b0) begin errors++; $display("FAIL reset_parity got %b expected 0", readback_parity); end
        pReset = 1'b0;
        @(negedge prog_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got %b expected 0", busy); end
    endtask

    task automatic test_nominal();
        int cyc_done, hs, done_hi, busy_after, stall_bad;
        preload(18'h3FFFF);
        do_load(8'hA5, 8'h3C, 8'h02, -1, 0, 1'b0, cyc_done, hs, done_hi, busy_after, stall_bad);
        checks++; if (cyc_done !== 22) begin errors++; $display("FAIL nominal_latency got %0d expected 22", cyc_done); end
        checks++; if (chain !== {2'b10, 8'h3C, 8'hA5}) begin errors++; $display("FAIL nominal_chain got %h expected %h", chain, {2'b10, 8'h3C, 8'hA5}); end
        checks++; if (readback_parity !== 1'b0) begin errors++; $display("FAIL nominal_parity got %b expected 0", readback_parity); end
        checks++; if (hs !== 3) begin errors++; $display("FAIL nominal_handshakes got %0d expected 3", hs); end
    endtask

    task automatic test_stall();
        int cyc_done, hs, done_hi, busy_after, stall_bad;
        preload(18'h3FFFF);
        do_load(8'hA5, 8'h3C, 8'h02, 1, 5, 1'b0, cyc_done, hs, done_hi, busy_after, stall_bad);
        checks++; if (cyc_done !== 27) begin errors++; $display("FAIL stall_latency got %0d expected 27", cyc_done); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_chain_activity got %0d expected 0", stall_bad); end
        checks++; if (chain !== {2'b10, 8'h3C, 8'hA5}) begin errors++; $display("FAIL stall_chain got %h expected %h", chain, {2'b10, 8'h3C, 8'hA5}); end
    endtask

    task automatic test_busy_done();
        int cyc_done, hs, done_hi, busy_after, stall_bad;
        preload(18'h3FFFF);
        do_load(8'hA5, 8'h3C, 8'h02, -1, 0, 1'b1, cyc_done, hs, done_hi, busy_after, stall_bad);
        checks++; if (hs !== 3) begin errors++; $display("FAIL protocol_handshakes got %0d expected 3", hs); end
        checks++; if (done_hi !== 1) begin errors++; $display("FAIL protocol_done_cycles got %0d expected 1", done_hi); end
        checks++; if (busy_after !== 0) begin errors++; $display("FAIL protocol_restart got %0d busy cycles expected 0", busy_after); end
        checks++; if (cyc_done !== 22) begin errors++; $display("FAIL protocol_latency got %0d expected 22", cyc_done); end
    endtask

    task automatic test_parity();
        int cyc_done, hs, done_hi, busy_after, stall_bad;
        preload(18'h3FFFE);
        do_load(8'hA5, 8'h3C, 8'h02, -1, 0, 1'b0, cyc_done, hs, done_hi, busy_after, stall_bad);
        checks++; if (readback_parity !== 1'b1) begin errors++; $display("FAIL parity_odd got %b expected 1", readback_parity); end
        repeat (3) @(negedge prog_clk);
        checks++; if (readback_parity !== 1'b1) begin errors++; $display("FAIL parity_hold got %b expected 1", readback_parity); end
        #2 pReset = 1'b1;
        #1;
        checks++; if (readback_parity !== 1'b0) begin errors++; $display("FAIL parity_async_reset got %b expected 0", readback_parity); end
        @(negedge prog_clk);
        pReset = 1'b0;
    endtask

    task automatic test_reset_midload();
        int cyc_done, hs, done_hi, busy_after, stall_bad, shifts;
        preload(18'h0);
        @(negedge prog_clk);
        start = 1'b1; word_valid = 1'b1; word_data = 8'hA5;
        @(posedge prog_clk); #1;
        start = 1'b0;
        shifts = 0;
        for (int k = 0; k < 40 && shifts < 7; k++) begin
            @(negedge prog_clk);
            if (shift_en === 1'b1) shifts++;
            @(posedge prog_clk);
        end
        checks++; if (shifts !== 7) begin errors++; $display("FAIL midload_shift_count got %0d expected 7", shifts); end
        #3 pReset = 1'b1;
        #1;
        checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL midload_shift_en got %b expected 0", shift_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midload_busy got %b expected 0", busy); end
        checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL midload_word_ready got %b expected 0", word_ready); end
        checks++; if (ccff_head !== 1'b0) begin errors++; $display("FAIL midload_ccff_head got %b expected 0", ccff_head); end
        @(negedge prog_clk);
        pReset = 1'b0;
        do_load(8'hFF, 8'hFF, 8'hFF, -1, 0, 1'b0, cyc_done, hs, done_hi, busy_after, stall_bad);
        checks++; if (chain !== 18'h3FFFF) begin errors++; $display("FAIL reload_chain got %h expected 3ffff", chain); end
        checks++; if (cyc_done !== 22) begin errors++; $display("FAIL reload_latency got %0d expected 22", cyc_done); end
    endtask

    task automatic test_exact_multiple();
        logic [7:0] words [2];
        int idx, cyc, cyc_done, hs, post;
        bit will_hs;
        words[0] = 8'h5A; words[1] = 8'hC3;
        idx = 0; cyc = 0; cyc_done = -1; hs = 0; post = 0;
        @(negedge prog_clk);
        start16 = 1'b1; valid16 = 1'b1; data16 = words[0];
        @(posedge prog_clk); #1;
        cyc = 1; start16 = 1'b0;
        for (int k = 0; k < 60 && post < 3; k++) begin
            @(negedge prog_clk);
            if (cyc_done >= 0) post++;
            if (done16 === 1'b1 && cyc_done < 0) cyc_done = cyc;
            valid16 = 1'b1;
            data16 = (idx < 2) ? words[idx] : 8'hEE;
            will_hs = (ready16 === 1'b1) && valid16;
            @(posedge prog_clk); #1;
            cyc++;
            if (will_hs) begin hs++; idx++; end
        end
        valid16 = 1'b0;
        checks++; if (cyc_done !== 19) begin errors++; $display("FAIL exact_latency got %0d expected 19", cyc_done); end
        checks++; if (hs !== 2) begin errors++; $display("FAIL exact_handshakes got %0d expected 2", hs); end
        checks++; if (chain16 !== {8'hC3, 8'h5A}) begin errors++; $display("FAIL exact_chain got %h expected c35a", chain16); end
        checks++; if (par16 !== 1'b1) begin errors++; $display("FAIL exact_parity got %b expected 1", par16); end
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL exact_busy_after got %b expected 0", busy16); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_busy_done();
        test_parity();
        test_reset_midload();
        test_exact_multiple();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Serialises configuration words from a host-side word stream onto a configuration-chain head (`ccff_head`) with a gated shift enable, for one chain segment such as a connection-block chain of `CHAIN_LEN` bits. Sits directly upstream of the chain's first `mux_*_mem` stage. Samples the bit falling out of `ccff_tail` on every shift and keeps a readback parity, so the previous configuration can be checked.

## Interface
Parameters:
- `WORD_W`, default 8: width of host configuration word.
- `CHAIN_LEN`, default 18: number of flops in the driven chain (cby: 6+6+2+2+2).
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: bit-counter width (derived, do not override).

Ports:
- `prog_clk`  input  1: configuration clock; all flops rise-edge.
- `pReset`  input  1: reset, asynchronous, active-high.
- `start`  input  1: one-cycle request to begin a load; honoured only in IDLE.
- `word_data`  input  WORD_W: configuration word; bit 0 is shifted first.
- `word_valid`  input  1: `word_data` valid.
- `word_ready`  output  1: loader accepts `word_data` this cycle.
- `ccff_head`  output  1: serial data into the chain.
- `shift_en`  output  1: enable for the external `prog_clk` gate of the chain; chain shifts at the edge ending any cycle where it is 1.
- `ccff_tail`  input  1: chain output, sampled when `shift_en`=1.
- `busy`  output  1: state is LOAD.
- `done`  output  1: one-cycle pulse at load completion.
- `readback_parity`  output  1: XOR of all `ccff_tail` samples of the current or last load.

## Operation
- Registers: `state` (IDLE, LOAD, DONE), `buf` (WORD_W), `buf_cnt` (0..WORD_W), `bit_cnt` (CNT_W), `rb_par`.
- All outputs decode from flops only. There is no combinational input-to-output path.
- IDLE:
  - `start`=1 → LOAD; clear `bit_cnt`, `buf_cnt` and `rb_par`.
  - In any other state, `start` is ignored.
- LOAD, word fetch:
  - `word_ready` = (`buf_cnt`==0) && (`bit_cnt` < CHAIN_LEN).
  - When `word_ready && word_valid`: `buf` ← `word_data`, `buf_cnt` ← WORD_W.
  - `shift_en` is 0 in a fetch cycle.
- LOAD, shift:
  - When `buf_cnt` != 0: `shift_en`=1 and `ccff_head`=`buf[0]`.
  - At the clock edge: `buf` ← `buf>>1`, `buf_cnt`--, `bit_cnt`++, `rb_par` ^= `ccff_tail`.
- LOAD, stall: when `buf_cnt`==0 and `word_valid`=0, then `shift_en`=0, `ccff_head`=0 and the chain holds.
- LOAD → DONE on the edge where `bit_cnt` reaches CHAIN_LEN. On that edge, clear `buf_cnt`; unshifted bits of the last word are discarded.
- DONE:
  - `done`=1 for exactly one cycle, then IDLE.
  - `readback_parity` holds its value until the next `start`.
- Bit order: the first bit shifted ends in the flop nearest `ccff_tail`. The host supplies the bitstream tail-first.
- Word count per load is `ceil(CHAIN_LEN/WORD_W)`. No more words are accepted after the last bit is counted.

## Timing
- Reset values:
  - `state`=IDLE.
  - `word_ready`=0, `ccff_head`=0, `shift_en`=0, `busy`=0, `done`=0, `readback_parity`=0.
  - All counters = 0.
- Reset asserted mid-LOAD: outputs go to reset values immediately (asynchronous). Chain contents are then undefined and a new `start` is required.
- Throughput: one fetch cycle plus up to WORD_W shift cycles per word, with no bubble beyond the fetch cycle when `word_valid` is held high.
- Latency for a full-valid stream, counted from the `start` edge to `done`=1:
  - `ceil(CHAIN_LEN/WORD_W)` fetch cycles + CHAIN_LEN shift cycles + 1.
  - Defaults: 3+18+1 = 22 cycles.
- `ccff_head` changes only on edges where the chain also shifts or `shift_en` is 0. This guarantees setup to the gated edge.
- `start` coincident with `done`: ignored (state is DONE, not IDLE).

## Test plan
- **Reset:** assert `pReset` asynchronously mid-cycle → all outputs 0 within the same cycle; `start` afterwards begins a clean load.
- **Nominal load:** defaults, `word_valid` always high, words 0xA5, 0x3C, 0x02, behavioural 18-flop chain preloaded with all ones:
  - `done` arrives 22 cycles after `start`.
  - Chain holds bits 0xA5, 0x3C, then `10b` in shift order.
  - `readback_parity`=0 (18 ones).
  - Bits 2..7 of 0x02 are never shifted.
- **Host stalls:** deassert `word_valid` for 5 cycles before word 2 → `shift_en`=0 during the stall, chain unchanged, final contents identical to the nominal load, `done` 5 cycles later.
- **Busy/done protocol:** pulse `start` during LOAD and in the DONE cycle → ignored, no extra words requested. Exactly 3 `word_ready`&&`word_valid` handshakes occur, and `done` is high for one cycle.
- **Reset mid-load:** assert `pReset` after 7 shifts → `shift_en`, `busy` and `word_ready` go to 0 at once. The next load of 0xFF, 0xFF, 0xFF yields a chain of all ones.
- **Exact-multiple length:** CHAIN_LEN=16, WORD_W=8 → 2 words, DONE reached without an extra fetch cycle, `done` 19 cycles after `start`.
